scan_chain_ctrl: RTL

Sequencer for one scan chain of asynchronously-reset scan flip-flops (scan-enable / scan-in muxed-D cells with active-low reset). It accepts parallel test patterns and serially loads them through the chain, then issues a one-cycle functional capture. The captured response is unloaded on the next load, or on a final flush shift, and returned as a parallel word. It sits between the on-chip test access logic and the chain's SE/SI/SO pins, and is clocked by the same CLK as the chain.

---
 rtl/scan_chain_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: sequencer for a single scan chain. It takes parallel test
// patterns, shifts them serially into the chain through SE/SI, pulses one
// functional capture cycle, and unloads the captured response from SO. The
// unload happens while the next pattern shifts in, or during a final flush
// with SI held low. The result is presented as a parallel word on resp.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_in,
  input  logic                 abort,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic                 resp_valid,
  output logic [CHAIN_LEN-1:0] resp,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CAPT  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state;
  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] resp_sh;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_nxt;
  logic                 have_resp;
  logic                 accept;
  logic [CHAIN_LEN-1:0] resp_final;

  // A new pattern can only be taken while idle or during the capture cycle,
  // and never while an abort is being requested.
  assign pat_ready = ((state == IDLE) || (state == CAPT)) && !abort;
  assign accept    = pat_valid && pat_ready;
  assign busy      = (state != IDLE);
  assign count_nxt = count + CNT_W'(1);

  // Shift register contents including the bit arriving on the current edge,
  // so the last shift edge can publish a complete response word.
  always_comb begin
    resp_final        = resp_sh;
    resp_final[count] = SO;
  end

  // Main sequencer: loads patterns, captures, and unloads responses.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state      <= IDLE;
      SE         <= 1'b0;
      SI         <= 1'b0;
      resp       <= '0;
      resp_valid <= 1'b0;
      count      <= '0;
      have_resp  <= 1'b0;
      pat_q      <= '0;
      resp_sh    <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        SE        <= 1'b0;
        SI        <= 1'b0;
        count     <= '0;
        have_resp <= 1'b0;
      end else if (accept) begin
        pat_q <= pat_in;
        SE    <= 1'b1;
        SI    <= pat_in[0];
        count <= '0;
        state <= SHIFT;
      end else begin
        case (state)
          IDLE: begin
            SE <= 1'b0;
          end
          SHIFT: begin
            resp_sh[count] <= SO;
            if (count == LAST) begin
              SE        <= 1'b0;
              SI        <= 1'b0;
              count     <= '0;
              state     <= CAPT;
              have_resp <= 1'b1;
              if (have_resp) begin
                resp       <= resp_final;
                resp_valid <= 1'b1;
              end
            end else begin
              count <= count_nxt;
              SI    <= pat_q[count_nxt];
            end
          end
          CAPT: begin
            SE    <= 1'b1;
            SI    <= 1'b0;
            count <= '0;
            state <= FLUSH;
          end
          FLUSH: begin
            resp_sh[count] <= SO;
            if (count == LAST) begin
              resp       <= resp_final;
              resp_valid <= 1'b1;
              SE         <= 1'b0;
              SI         <= 1'b0;
              count      <= '0;
              have_resp  <= 1'b0;
              state      <= IDLE;
            end else begin
              count <= count_nxt;
              SI    <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            SE    <= 1'b0;
            SI    <= 1'b0;
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule
